// File: rtl/wf_neopixel_frame_arbiter_if.sv
// Requester-side pixel write / commit handshake into the frame arbiter.
interface wf_neopixel_frame_arbiter_if;
    logic        req;
    logic        cmt;
    logic [7:0]  addr;
    logic [23:0] data;
    logic        gnt;

    modport master (output req, cmt, addr, data, input gnt);
    modport slave  (input req, cmt, addr, data, output gnt);
endinterface

// File: rtl/wf_neopixel_frame_arbiter.sv
// Double-buffered neopixel frame store: two round-robin writers fill the back bank,
// reads come from the front bank, banks swap only at a frame boundary, then front is copied to back.
module wf_neopixel_frame_arbiter #(
    parameter int unsigned NUM_OF_PIXELS = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    wf_neopixel_frame_arbiter_if.slave        req_a_if,
    wf_neopixel_frame_arbiter_if.slave        req_b_if,
    input  logic [7:0]                        np_rd_addr,
    output logic [23:0]                       np_rd_data,
    output logic                              frame_swap,
    output logic                              wr_err,
    output logic                              busy
);
    localparam int unsigned AW = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
    localparam logic [7:0]  NPIX  = 8'(NUM_OF_PIXELS);
    localparam logic [7:0]  LAST  = 8'(NUM_OF_PIXELS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SWAP_WAIT, ST_COPY} state_t;

    state_t      state_q, state_d;
    logic        front_q, front_d;
    logic        ptr_q, ptr_d;
    logic [7:0]  idx_q, idx_d;
    logic        gnt_a_q, gnt_a_d;
    logic        gnt_b_q, gnt_b_d;
    logic        frame_swap_q, frame_swap_d;
    logic        wr_err_q, wr_err_d;
    logic [7:0]  prev_addr_q;
    logic [23:0] np_rd_data_q, np_rd_data_d;

    logic [23:0] bank0_q [NUM_OF_PIXELS];
    logic [23:0] bank1_q [NUM_OF_PIXELS];

    logic          we_c;
    logic [AW-1:0] waddr_c;
    logic [23:0]   wdata_c;

    // A requester that was just granted is still holding req this cycle; skip it once.
    logic        el_a, el_b, sel_b, boundary_c;
    logic        g_cmt;
    logic [7:0]  g_addr;
    logic [23:0] g_data;

    assign el_a       = req_a_if.req && !gnt_a_q;
    assign el_b       = req_b_if.req && !gnt_b_q;
    assign sel_b      = el_b && (!el_a || ptr_q);
    assign g_cmt      = sel_b ? req_b_if.cmt  : req_a_if.cmt;
    assign g_addr     = sel_b ? req_b_if.addr : req_a_if.addr;
    assign g_data     = sel_b ? req_b_if.data : req_a_if.data;
    assign boundary_c = (prev_addr_q != 8'd0) && (np_rd_addr == 8'd0);

    always_comb begin
        state_d      = state_q;
        front_d      = front_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        gnt_a_d      = 1'b0;
        gnt_b_d      = 1'b0;
        frame_swap_d = 1'b0;
        wr_err_d     = 1'b0;
        we_c         = 1'b0;
        waddr_c      = '0;
        wdata_c      = '0;
        case (state_q)
            ST_IDLE: begin
                if (el_a || el_b) begin
                    gnt_a_d = !sel_b;
                    gnt_b_d = sel_b;
                    ptr_d   = !sel_b;
                    if (g_cmt) begin
                        state_d = ST_SWAP_WAIT;
                    end else if (g_addr < NPIX) begin
                        we_c    = 1'b1;
                        waddr_c = g_addr[AW-1:0];
                        wdata_c = g_data;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
            end
            ST_SWAP_WAIT: begin
                if (boundary_c) begin
                    front_d      = !front_q;
                    frame_swap_d = 1'b1;
                    idx_d        = 8'd0;
                    state_d      = ST_COPY;
                end
            end
            ST_COPY: begin
                we_c    = 1'b1;
                waddr_c = idx_q[AW-1:0];
                wdata_c = front_q ? bank1_q[idx_q[AW-1:0]] : bank0_q[idx_q[AW-1:0]];
                idx_d   = idx_q + 8'd1;
                if (idx_q == LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read port: one-cycle latency from the front bank, zero outside the pixel range.
    always_comb begin
        np_rd_data_d = '0;
        if (np_rd_addr < NPIX)
            np_rd_data_d = front_q ? bank1_q[np_rd_addr[AW-1:0]] : bank0_q[np_rd_addr[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            front_q      <= 1'b0;
            ptr_q        <= 1'b0;
            idx_q        <= 8'd0;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            frame_swap_q <= 1'b0;
            wr_err_q     <= 1'b0;
            prev_addr_q  <= 8'd0;
            np_rd_data_q <= 24'd0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            frame_swap_q <= frame_swap_d;
            wr_err_q     <= wr_err_d;
            prev_addr_q  <= np_rd_addr;
            np_rd_data_q <= np_rd_data_d;
        end
    end

    // Bank storage is intentionally unreset; writes always target the back bank.
    always_ff @(posedge clk) begin
        if (we_c) begin
            if (front_q) bank0_q[waddr_c] <= wdata_c;
            else         bank1_q[waddr_c] <= wdata_c;
        end
    end

    assign req_a_if.gnt = gnt_a_q;
    assign req_b_if.gnt = gnt_b_q;
    assign np_rd_data   = np_rd_data_q;
    assign frame_swap   = frame_swap_q;
    assign wr_err       = wr_err_q;
    assign busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_wf_neopixel_frame_arbiter.sv
// Self-checking bench for wf_neopixel_frame_arbiter (NUM_OF_PIXELS = 8).
module tb_wf_neopixel_frame_arbiter;
    logic        clk;
    logic        rst;
    logic [7:0]  np_rd_addr;
    logic [23:0] np_rd_data;
    logic        frame_swap;
    logic        wr_err;
    logic        busy;

    wf_neopixel_frame_arbiter_if a_if();
    wf_neopixel_frame_arbiter_if b_if();

    wf_neopixel_frame_arbiter #(.NUM_OF_PIXELS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a_if   (a_if),
        .req_b_if   (b_if),
        .np_rd_addr (np_rd_addr),
        .np_rd_data (np_rd_data),
        .frame_swap (frame_swap),
        .wr_err     (wr_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [23:0] data;
        logic        exp_err;
    } wr_vec_t;

    typedef struct {
        logic exp_a;
        logic exp_b;
    } arb_vec_t;

    wr_vec_t     wv [12];
    arb_vec_t    av [5];
    logic [23:0] ref_mem [8];
    logic [23:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard read: expectation queued when the address is driven, popped when data appears.
    task automatic rd_check(input logic [7:0] addr, input logic [23:0] exp);
        logic [23:0] e;
        exp_q.push_back(exp);
        np_rd_addr = addr;
        tick();
        e = exp_q.pop_front();
        chk($sformatf("rd_data[%0d]", addr), 32'(np_rd_data), 32'(e));
    endtask

    task automatic req_txn(input bit side, input bit cmt, input logic [7:0] addr,
                           input logic [23:0] data, output bit got_err, output bit got_busy);
        bit granted;
        granted  = 1'b0;
        got_err  = 1'b0;
        got_busy = 1'b0;
        if (!side) begin a_if.req = 1'b1; a_if.cmt = cmt; a_if.addr = addr; a_if.data = data; end
        else       begin b_if.req = 1'b1; b_if.cmt = cmt; b_if.addr = addr; b_if.data = data; end
        for (int n = 0; n < 40 && !granted; n++) begin
            tick();
            if ((side ? b_if.gnt : a_if.gnt) == 1'b1) begin
                granted  = 1'b1;
                got_err  = wr_err;
                got_busy = busy;
            end
        end
        if (!side) a_if.req = 1'b0; else b_if.req = 1'b0;
        chk("grant_seen", 32'(granted), 32'(1));
        if (granted) begin
            tick();
            chk("gnt_one_cycle", 32'(side ? b_if.gnt : a_if.gnt), 32'(0));
        end
    endtask

    task automatic boundary_swap(output int swaps, output int busy_cyc);
        bool_done: begin end
        swaps    = 0;
        busy_cyc = 0;
        np_rd_addr = 8'd8;
        tick();
        np_rd_addr = 8'd0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (frame_swap) swaps++;
            if (swaps > 0 && busy) busy_cyc++;
            if (swaps > 0 && !busy) break;
        end
    endtask

    initial begin
        bit e, bz;
        int swaps, bcyc, gnt_busy, gseen, gbusy;

        wv[0]  = '{8'd0,   24'h110000, 1'b0};
        wv[1]  = '{8'd1,   24'h002200, 1'b0};
        wv[2]  = '{8'd2,   24'h000033, 1'b0};
        wv[3]  = '{8'd3,   24'h123456, 1'b0};
        wv[4]  = '{8'd4,   24'hA5A5A5, 1'b0};
        wv[5]  = '{8'd5,   24'h5A5A5A, 1'b0};
        wv[6]  = '{8'd6,   24'hFFFFFF, 1'b0};
        wv[7]  = '{8'd7,   24'h0F0F0F, 1'b0};
        wv[8]  = '{8'd8,   24'hDEAD00, 1'b1};
        wv[9]  = '{8'd200, 24'hBEEF00, 1'b1};
        wv[10] = '{8'd3,   24'h00FF00, 1'b0};
        wv[11] = '{8'd255, 24'hC0FFEE, 1'b1};
        av[0] = '{1'b1, 1'b0};
        av[1] = '{1'b0, 1'b1};
        av[2] = '{1'b1, 1'b0};
        av[3] = '{1'b0, 1'b1};
        av[4] = '{1'b0, 1'b0};

        a_if.req = 0; a_if.cmt = 0; a_if.addr = 0; a_if.data = 0;
        b_if.req = 0; b_if.cmt = 0; b_if.addr = 0; b_if.data = 0;
        np_rd_addr = 8'd9;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_gnt_a", 32'(a_if.gnt), 32'(0));
        chk("rst_gnt_b", 32'(b_if.gnt), 32'(0));
        chk("rst_frame_swap", 32'(frame_swap), 32'(0));
        chk("rst_wr_err", 32'(wr_err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rd_data", 32'(np_rd_data), 32'(0));
        rst = 1'b0;
        rd_check(8'd9, 24'd0);
        chk("idle_busy", 32'(busy), 32'(0));
        np_rd_addr = 8'd0;

        // Table-driven writes into the back bank, including out-of-range drops.
        for (int i = 0; i < 12; i++) begin
            req_txn(1'b0, 1'b0, wv[i].addr, wv[i].data, e, bz);
            chk($sformatf("wr_err_vec%0d", i), 32'(e), 32'(wv[i].exp_err));
            if (wv[i].addr < 8'd8) ref_mem[wv[i].addr[2:0]] = wv[i].data;
        end
        req_txn(1'b0, 1'b1, 8'd0, 24'd0, e, bz);
        chk("commit_busy", 32'(bz), 32'(1));
        chk("swap_wait_busy", 32'(busy), 32'(1));
        boundary_swap(swaps, bcyc);
        chk("swap1_pulses", 32'(swaps), 32'(1));
        chk("swap1_copy_cycles", 32'(bcyc), 32'(8));
        for (int i = 0; i < 10; i++)
            rd_check(8'(i), (i < 8) ? ref_mem[i] : 24'd0);

        // B held through SWAP_WAIT and COPY; lands in the back bank only.
        req_txn(1'b0, 1'b1, 8'd0, 24'd0, e, bz);
        b_if.req = 1'b1; b_if.cmt = 1'b0; b_if.addr = 8'd5; b_if.data = 24'hABCDEF;
        gnt_busy = 0; gseen = 0; gbusy = 1; swaps = 0;
        for (int n = 0; n < 60 && gseen == 0; n++) begin
            if (n == 3) np_rd_addr = 8'd8;
            if (n == 4) np_rd_addr = 8'd0;
            tick();
            if (frame_swap) swaps++;
            if (b_if.gnt && busy) gnt_busy++;
            if (b_if.gnt) begin gseen = 1; gbusy = 32'(busy); end
        end
        b_if.req = 1'b0;
        chk("held_b_granted", 32'(gseen), 32'(1));
        chk("held_b_no_gnt_while_busy", 32'(gnt_busy), 32'(0));
        chk("held_b_gnt_idle", 32'(gbusy), 32'(0));
        chk("swap2_pulses", 32'(swaps), 32'(1));
        tick();
        rd_check(8'd5, ref_mem[5]);
        req_txn(1'b0, 1'b1, 8'd0, 24'd0, e, bz);
        boundary_swap(swaps, bcyc);
        chk("swap3_pulses", 32'(swaps), 32'(1));
        ref_mem[5] = 24'hABCDEF;
        rd_check(8'd5, ref_mem[5]);
        rd_check(8'd4, ref_mem[4]);

        // Round-robin with both requesters held continuously.
        do_reset();
        a_if.req = 1'b1; a_if.cmt = 1'b0; a_if.addr = 8'd0; a_if.data = 24'h0A0A0A;
        b_if.req = 1'b1; b_if.cmt = 1'b0; b_if.addr = 8'd1; b_if.data = 24'h0B0B0B;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin a_if.req = 1'b0; b_if.req = 1'b0; end
            tick();
            if (i == 3) begin a_if.req = 1'b0; b_if.req = 1'b0; end
            chk($sformatf("rr_gnt_a%0d", i), 32'(a_if.gnt), 32'(av[i].exp_a));
            chk($sformatf("rr_gnt_b%0d", i), 32'(b_if.gnt), 32'(av[i].exp_b));
        end

        // Reset at copy pixel 4: front returns to bank0, partial copy abandoned.
        req_txn(1'b0, 1'b0, 8'd2, 24'h222222, e, bz);
        req_txn(1'b0, 1'b0, 8'd6, 24'h666666, e, bz);
        req_txn(1'b0, 1'b1, 8'd0, 24'd0, e, bz);
        np_rd_addr = 8'd8;
        tick();
        np_rd_addr = 8'd0;
        gseen = 0;
        for (int n = 0; n < 10 && gseen == 0; n++) begin
            tick();
            if (frame_swap) gseen = 1;
        end
        chk("swap4_seen", 32'(gseen), 32'(1));
        for (int n = 0; n < 4; n++) tick();
        #2 rst = 1'b1;
        #1;
        chk("midcopy_rst_busy", 32'(busy), 32'(0));
        chk("midcopy_rst_swap", 32'(frame_swap), 32'(0));
        tick();
        rst = 1'b0;
        swaps = 0; bcyc = 0;
        for (int n = 0; n < 12; n++) begin
            np_rd_addr = (n % 2 == 0) ? 8'd8 : 8'd0;
            tick();
            if (frame_swap) swaps++;
            if (busy) bcyc++;
        end
        chk("post_rst_no_swap", 32'(swaps), 32'(0));
        chk("post_rst_no_busy", 32'(bcyc), 32'(0));
        np_rd_addr = 8'd0;
        tick();
        rd_check(8'd6, ref_mem[6]);
        rd_check(8'd2, 24'h222222);
        req_txn(1'b1, 1'b1, 8'd0, 24'd0, e, bz);
        boundary_swap(swaps, bcyc);
        chk("swap5_pulses", 32'(swaps), 32'(1));
        chk("swap5_copy_cycles", 32'(bcyc), 32'(8));
        rd_check(8'd6, 24'h666666);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
